dsm2_core: RTL and testbench
============================

Name: dsm2_core

Overview:
- Second-order, single-bit delta-sigma modulator core. It consumes the interpolated signed sample stream from the interpolator at the full modulator clock rate, one sample per clock.
- Produces the 1-bit output stream that drives the output DAC/pad.
- Includes integrator saturation, overload detection with automatic integrator recovery, and a zero-mean idle pattern when disabled.

Parameters:
- IN_W, 16: width of signed two's-complement input sample. Full scale FS = 2^(IN_W-1).
- ACC_W, 20: width of each signed integrator. Must be ≥ IN_W+3.
- OVL_CYC, 8: consecutive saturated cycles that trigger overload recovery (1..255).
- RECOVER_CYC, 16: length of the recovery phase in cycles (1..255).

Ports:
- clock, input, 1: modulator clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: 1 = modulate din; 0 = idle.
- din, input, IN_W: signed interpolated sample, sampled every cycle.
- clear_ovl, input, 1: clears ovl_sticky.
- dsm_out, output, 1: modulator bitstream (1 = +FS, 0 = −FS).
- overload, output, 1: one-cycle pulse on RUN→RECOVER.
- ovl_sticky, output, 1: set by overload, held until clear_ovl or reset.
- state_o, output, 2: 00 IDLE, 01 RUN, 10 RECOVER.

Behaviour:
- Reset (synchronous, active-high) has priority over everything. On reset:
  - x_r, int1, int2, sat_cnt, rec_cnt = 0; state = IDLE.
  - dsm_out = 0, overload = 0, ovl_sticky = 0.
- Feedback: fb = dsm_out ? +FS : −FS, sign-extended to ACC_W.
- RUN datapath, every cycle:
  - x_r <= din (sign-extended).
  - s1 = int1 + x_r − fb.
  - s2 = int2 + int1 − 2·fb. int2 uses the OLD int1.
  - int1 <= sat(s1); int2 <= sat(s2).
  - dsm_out <= (sat(s2) ≥ 0).
  - sat() clamps to ±(2^(ACC_W−1)−1). Sums are computed at ACC_W+2 bits, so intermediate wrap is forbidden.
- Latency: din at edge k → x_r at k+1 → int1 at k+2 → int2/dsm_out at k+3.
- Saturation counter (RUN only):
  - sat_cnt increments when either clamp is active this cycle; otherwise it resets to 0.
  - sat_cnt saturates at OVL_CYC.
- State machine:
  - IDLE: int1/int2/x_r held at 0; dsm_out <= ~dsm_out (1010… idle pattern). enable=1 → RUN on the next edge.
  - RUN:
    - enable=0 → IDLE; integrators cleared on entry.
    - sat_cnt reaching OVL_CYC → RECOVER. That same edge: overload=1 for one cycle, ovl_sticky <= 1, int1/int2/sat_cnt <= 0, rec_cnt <= 0.
  - RECOVER:
    - Integrators held at 0; dsm_out toggles.
    - rec_cnt increments each cycle. At rec_cnt == RECOVER_CYC−1 → RUN if enable=1, else IDLE.
    - enable falling mid-RECOVER → IDLE immediately.
- ovl_sticky: a set and clear_ovl in the same cycle → set wins.
- Reset mid-RECOVER or mid-RUN returns to the full reset state; no pulse on overload.
- din is ignored outside RUN. Its x_r capture still occurs but is forced to 0.

Test Plan:
- Reset → all outputs 0 and state_o = 00. Then hold enable=0 for 8 cycles → dsm_out = 1,0,1,0… and state_o stays 00.
- enable=1, din=0 for 2048 cycles → ones density 50% ±0.5%; no overload.
- enable=1, din=+FS/2 (0x4000) → ones density over 4096 cycles = 75% ±1%. With din=−FS/2 → 25% ±1%.
- Latency check: from the settled din=0 pattern, step din to 0x4000 at edge k → int1 changes at k+2, dsm_out first reflects the step at k+3.
- din=0x7FFF held (unstable) → clamp engages, overload pulses exactly 1 cycle after OVL_CYC saturated cycles, ovl_sticky=1. dsm_out then toggles for 16 cycles and state returns to 01 with int1=int2=0.
- Assert reset during RECOVER → next cycle state_o=00, ovl_sticky=0, overload never pulses. Separately, pulse clear_ovl with no new overload → ovl_sticky clears next edge.

Source files
------------

// File: rtl/dsm2_core.sv
// Second-order single-bit delta-sigma modulator with integrator clamping,
// overload detection/recovery and a toggling idle pattern.
module dsm2_core #(
   parameter int IN_W        = 16,
   parameter int ACC_W       = 20,
   parameter int OVL_CYC     = 8,
   parameter int RECOVER_CYC = 16
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            enable,
   input  logic [IN_W-1:0] din,
   input  logic            clear_ovl,
   output logic            dsm_out,
   output logic            overload,
   output logic            ovl_sticky,
   output logic [1:0]      state_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUN     = 2'b01,
      ST_RECOVER = 2'b10
   } state_t;

   localparam int SW = ACC_W + 2;
   localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX;
   localparam logic signed [SW-1:0] FS_EXT  = {{(SW-IN_W){1'b0}}, 1'b1, {(IN_W-1){1'b0}}};

   state_t                    state_q, state_d;
   logic signed [ACC_W-1:0]   x_q, x_d;
   logic signed [ACC_W-1:0]   int1_q, int1_d;
   logic signed [ACC_W-1:0]   int2_q, int2_d;
   logic [7:0]                sat_cnt_q, sat_cnt_d;
   logic [7:0]                rec_cnt_q, rec_cnt_d;
   logic                      dsm_q, dsm_d;
   logic                      ovl_q, ovl_d;
   logic                      sticky_q, sticky_d;

   logic signed [SW-1:0]      fb, xe, i1e, i2e, s1, s2;
   logic signed [ACC_W-1:0]   sat1, sat2;
   logic                      hit;

   function automatic logic signed [ACC_W-1:0] clamp(input logic signed [SW-1:0] v);
      if (v > SAT_MAX)      return SAT_MAX[ACC_W-1:0];
      else if (v < SAT_MIN) return SAT_MIN[ACC_W-1:0];
      else                  return v[ACC_W-1:0];
   endfunction

   // Sums carry two guard bits so the clamp sees the true value, never a wrap.
   always_comb begin
      fb   = dsm_q ? FS_EXT : -FS_EXT;
      xe   = {{2{x_q[ACC_W-1]}}, x_q};
      i1e  = {{2{int1_q[ACC_W-1]}}, int1_q};
      i2e  = {{2{int2_q[ACC_W-1]}}, int2_q};
      s1   = i1e + xe - fb;
      s2   = i2e + i1e - (fb <<< 1);
      sat1 = clamp(s1);
      sat2 = clamp(s2);
      hit  = (s1 > SAT_MAX) | (s1 < SAT_MIN) | (s2 > SAT_MAX) | (s2 < SAT_MIN);
   end

   always_comb begin
      state_d   = state_q;
      x_d       = '0;
      int1_d    = '0;
      int2_d    = '0;
      sat_cnt_d = '0;
      rec_cnt_d = '0;
      dsm_d     = ~dsm_q;
      ovl_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else begin
               x_d   = {{(ACC_W-IN_W){din[IN_W-1]}}, din};
               dsm_d = ~sat2[ACC_W-1];
               if (hit && sat_cnt_q == 8'(OVL_CYC-1)) begin
                  state_d = ST_RECOVER;
                  ovl_d   = 1'b1;
               end else begin
                  int1_d    = sat1;
                  int2_d    = sat2;
                  sat_cnt_d = hit ? sat_cnt_q + 8'd1 : '0;
               end
            end
         end
         ST_RECOVER: begin
            if (!enable)                               state_d = ST_IDLE;
            else if (rec_cnt_q == 8'(RECOVER_CYC-1))   state_d = ST_RUN;
            else                                       rec_cnt_d = rec_cnt_q + 8'd1;
         end
         default: state_d = ST_IDLE;
      endcase
      sticky_d = ovl_d | (sticky_q & ~clear_ovl);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         x_q       <= '0;
         int1_q    <= '0;
         int2_q    <= '0;
         sat_cnt_q <= '0;
         rec_cnt_q <= '0;
         dsm_q     <= 1'b0;
         ovl_q     <= 1'b0;
         sticky_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         int1_q    <= int1_d;
         int2_q    <= int2_d;
         sat_cnt_q <= sat_cnt_d;
         rec_cnt_q <= rec_cnt_d;
         dsm_q     <= dsm_d;
         ovl_q     <= ovl_d;
         sticky_q  <= sticky_d;
      end
   end

   assign dsm_out    = dsm_q;
   assign overload   = ovl_q;
   assign ovl_sticky = sticky_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_dsm2_core.sv
// Self-checking bench for dsm2_core: vector table, density/latency/overload
// sequences and randomized traffic against a cycle-level arithmetic model.
module tb_dsm2_core;

   localparam longint FS  = 32768;
   localparam longint LIM = 524287;
   localparam int     OVL = 8;
   localparam int     RC  = 16;

   logic        clock = 1'b0;
   logic        rst = 1'b1, en = 1'b0, clr = 1'b0;
   logic [15:0] d_in = '0;
   logic        dsm_out, overload, ovl_sticky;
   logic [1:0]  state_o;

   int checks = 0;
   int errors = 0;

   dsm2_core #(.IN_W(16), .ACC_W(20), .OVL_CYC(OVL), .RECOVER_CYC(RC)) dut (
      .clock(clock), .reset(rst), .enable(en), .din(d_in), .clear_ovl(clr),
      .dsm_out(dsm_out), .overload(overload), .ovl_sticky(ovl_sticky), .state_o(state_o)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model: states 0 idle, 1 run, 2 recover; plain integer arithmetic.
   typedef struct {
      int     st;
      longint xr, i1, i2;
      int     sc, rc;
      bit     dout, ovl, sticky;
   } mdl_t;

   mdl_t m;

   function automatic longint clampv(input longint v);
      if (v > LIM)  return LIM;
      if (v < -LIM) return -LIM;
      return v;
   endfunction

   function automatic mdl_t mstep(input mdl_t c, input bit r, input bit e, input longint d, input bit cl);
      mdl_t   n;
      longint fb, s1, s2, c1, c2;
      bit     set;
      n = c;
      set = 0;
      if (r) begin
         n = '{default: 0};
         return n;
      end
      n.ovl = 0;
      if (c.st == 1 && e) begin
         fb = c.dout ? FS : -FS;
         s1 = c.i1 + c.xr - fb;
         s2 = c.i2 + c.i1 - 2 * fb;
         c1 = clampv(s1);
         c2 = clampv(s2);
         n.xr = d;
         n.dout = (c2 >= 0);
         n.sc = (c1 != s1 || c2 != s2) ? c.sc + 1 : 0;
         if (n.sc >= OVL) begin
            n.st = 2; n.ovl = 1; set = 1;
            n.i1 = 0; n.i2 = 0; n.sc = 0; n.rc = 0;
         end else begin
            n.i1 = c1; n.i2 = c2;
         end
      end else begin
         n.xr = 0; n.i1 = 0; n.i2 = 0; n.sc = 0;
         n.dout = !c.dout;
         if (c.st == 0) begin
            n.rc = 0;
            if (e) n.st = 1;
         end else if (c.st == 1) begin
            n.st = 0; n.rc = 0;
         end else if (!e) begin
            n.st = 0; n.rc = 0;
         end else if (c.rc == RC - 1) begin
            n.st = 1; n.rc = 0;
         end else begin
            n.rc = c.rc + 1;
         end
      end
      n.sticky = set ? 1'b1 : (cl ? 1'b0 : c.sticky);
      return n;
   endfunction

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      logic [4:0] act, exp;
      @(posedge clock);
      m = mstep(m, rst, en, longint'($signed(d_in)), clr);
      @(negedge clock);
      act = {dsm_out, overload, ovl_sticky, state_o};
      exp = {m.dout, m.ovl, m.sticky, 2'(m.st)};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL model dsm/ovl/stk/st: got %b required %b at %0t", act, exp, $time);
      end
   endtask

   task automatic wait_ovl(input int limit, output bit found);
      found = 0;
      for (int i = 0; i < limit && !found; i++) begin
         tick();
         if (overload) found = 1;
      end
      chk("overload_seen", longint'(found), 1);
   endtask

   typedef struct {
      bit          r, e, c;
      logic [15:0] d;
      bit          x_dsm, x_ovl, x_stk;
      bit [1:0]    x_st;
   } vec_t;

   vec_t vt[$];

   initial begin
      int ones, reclen, toggles, pulses;
      bit found, prev;
      bit sh_out[2];
      mdl_t sh;

      m = '{default: 0};
      // reset, 8 idle cycles, then din=0 RUN start-up
      vt.push_back('{1, 0, 0, 16'h0, 0, 0, 0, 2'b00});
      vt.push_back('{1, 0, 0, 16'h0, 0, 0, 0, 2'b00});
      for (int i = 0; i < 8; i++)
         vt.push_back('{0, 0, 0, 16'h0, (i % 2 == 0), 0, 0, 2'b00});
      vt.push_back('{0, 1, 0, 16'h0, 1, 0, 0, 2'b01});
      vt.push_back('{0, 1, 0, 16'h0, 0, 0, 0, 2'b01});
      vt.push_back('{0, 1, 0, 16'h0, 0, 0, 0, 2'b01});
      vt.push_back('{0, 1, 0, 16'h0, 1, 0, 0, 2'b01});
      vt.push_back('{0, 1, 0, 16'h0, 1, 0, 0, 2'b01});
      vt.push_back('{0, 1, 0, 16'h0, 0, 0, 0, 2'b01});

      @(negedge clock);
      foreach (vt[i]) begin
         rst = vt[i].r; en = vt[i].e; clr = vt[i].c; d_in = vt[i].d;
         tick();
         chk("vec_dsm", dsm_out, vt[i].x_dsm);
         chk("vec_ovl", overload, vt[i].x_ovl);
         chk("vec_sticky", ovl_sticky, vt[i].x_stk);
         chk("vec_state", state_o, vt[i].x_st);
      end

      // ones density for din = 0, +FS/2, -FS/2
      ones = 0;
      for (int i = 0; i < 2048; i++) begin tick(); ones += dsm_out; end
      chk("density_zero_ok", longint'(ones >= 1014 && ones <= 1034), 1);
      chk("zero_no_overload", ovl_sticky, 0);

      d_in = 16'h4000;
      for (int i = 0; i < 64; i++) tick();
      ones = 0;
      for (int i = 0; i < 4096; i++) begin tick(); ones += dsm_out; end
      chk("density_pos_half_ok", longint'(ones >= 3031 && ones <= 3113), 1);

      d_in = 16'hC000;
      for (int i = 0; i < 64; i++) tick();
      ones = 0;
      for (int i = 0; i < 4096; i++) begin tick(); ones += dsm_out; end
      chk("density_neg_half_ok", longint'(ones >= 983 && ones <= 1065), 1);

      // latency: a step must not reach dsm_out before the third edge
      d_in = 16'h0000;
      for (int i = 0; i < 64; i++) tick();
      sh = m;
      for (int i = 0; i < 2; i++) begin
         sh = mstep(sh, 0, 1, 0, 0);
         sh_out[i] = sh.dout;
      end
      d_in = 16'h4000;
      tick(); chk("latency_k1", dsm_out, sh_out[0]);
      tick(); chk("latency_k2", dsm_out, sh_out[1]);
      tick();

      // overload and recovery
      d_in = 16'h7FFF;
      wait_ovl(3000, found);
      if (found) begin
         chk("ovl_state", state_o, 2);
         chk("ovl_sticky_set", ovl_sticky, 1);
         prev = dsm_out; reclen = 1; toggles = 0;
         for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0) chk("ovl_pulse_width", overload, 0);
            if (dsm_out != prev) toggles++;
            prev = dsm_out;
            if (state_o != 2'b10) break;
            reclen++;
         end
         chk("recover_length", reclen, RC);
         chk("recover_toggles", toggles, RC);
         chk("recover_exit_state", state_o, 1);
      end

      // reset in the middle of RECOVER
      wait_ovl(3000, found);
      for (int i = 0; i < 4; i++) tick();
      chk("pre_reset_state", state_o, 2);
      rst = 1;
      tick();
      chk("reset_rec_state", state_o, 0);
      chk("reset_rec_sticky", ovl_sticky, 0);
      chk("reset_rec_overload", overload, 0);
      chk("reset_rec_dsm", dsm_out, 0);
      rst = 0; en = 0; pulses = 0;
      for (int i = 0; i < 10; i++) begin tick(); pulses += overload; end
      chk("reset_no_pulse", pulses, 0);

      // set and clear together: set wins, then clear takes effect
      en = 1; clr = 1;
      wait_ovl(3000, found);
      chk("set_beats_clear", ovl_sticky, 1);
      tick();
      chk("held_clear", ovl_sticky, 0);
      clr = 0;
      wait_ovl(3000, found);
      en = 0;
      for (int i = 0; i < 5; i++) tick();
      chk("sticky_held", ovl_sticky, 1);
      clr = 1; tick(); chk("clear_pulse", ovl_sticky, 0);
      clr = 0; tick(); chk("clear_stays", ovl_sticky, 0);

      // randomized traffic against the model
      en = 1;
      for (int blk = 0; blk < 16; blk++) begin
         int mode;
         mode = $urandom_range(0, 3);
         for (int i = 0; i < 256; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 63) == 0) en = ~en;
            clr = ($urandom_range(0, 31) == 0);
            case (mode)
               0: d_in = 16'($signed($urandom_range(0, 16383)) - 8192);
               1: d_in = 16'($urandom);
               2: d_in = 16'h7FFF;
               default: d_in = 16'h8000;
            endcase
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
